comm_master_n: RTL and testbench

- Parametrised command transmitter. Latches an N-byte command in one cycle and serialises it over a built-in 8N1 UART transmitter, most-significant byte first.
- Can append a checksum byte.
- Reports completion with a sticky flag and flags commands that arrive while it is busy.
- Sits between the command-generation logic (remote/test host side) and the TX pin; drives the link to the maze-runner receiver.

---
 rtl/comm_master_n.sv | 145 ++++++++++++++
 tb/tb_comm_master_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/comm_master_n.sv
// Command transmitter: latches an N-byte command and serialises it MSB-byte first
// over an 8N1 UART, with an optional inverted-sum checksum byte.
module comm_master_n #(
  parameter int NUM_BYTES = 2,
  parameter int BAUD_DIV  = 2604,
  parameter int CKSUM_EN  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] cmd,
  input  logic                   snd_cmd,
  output logic                   TX,
  output logic                   cmd_rdy,
  output logic                   cmd_cmplt,
  output logic                   cmd_drop
);

  localparam int TOT = NUM_BYTES + ((CKSUM_EN != 0) ? 1 : 0);
  localparam int BYW = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int BDW = $clog2(BAUD_DIV);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t                 state_q, state_d;
  logic [8*NUM_BYTES-1:0] hold_q;
  logic [7:0]             cksum_q;
  logic [7:0]             shf_q, shf_d;
  logic [BDW-1:0]         baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [BYW-1:0]         byte_q, byte_d;
  logic                   tx_q, tx_d;
  logic                   cmplt_q, cmplt_d;
  logic                   drop_q, drop_d;
  logic                   accept;

  function automatic logic [7:0] calc_cksum(input logic [8*NUM_BYTES-1:0] c);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < NUM_BYTES; k++) s = s + c[8*k +: 8];
    return ~s;
  endfunction

  // Byte index 0 is the most significant payload byte; index NUM_BYTES is the checksum.
  function automatic logic [7:0] pick_byte(input logic [8*NUM_BYTES-1:0] h,
                                           input logic [7:0] c,
                                           input logic [BYW-1:0] idx);
    logic [7:0] b;
    b = c;
    for (int k = 0; k < NUM_BYTES; k++)
      if (idx == BYW'(NUM_BYTES-1-k)) b = h[8*k +: 8];
    return b;
  endfunction

  assign accept = (state_q == IDLE) && snd_cmd;

  always_comb begin
    state_d = state_q;
    shf_d   = shf_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    cmplt_d = cmplt_q;
    drop_d  = snd_cmd && (state_q == XMIT);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (snd_cmd) begin
          state_d = XMIT;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          shf_d   = cmd[8*NUM_BYTES-1 -: 8];
          cmplt_d = 1'b0;
        end
      end
      XMIT: begin
        if (baud_q == BDW'(BAUD_DIV-1)) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (byte_q == BYW'(TOT-1)) begin
              state_d = IDLE;
              tx_d    = 1'b1;
              cmplt_d = 1'b1;
              byte_d  = '0;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_d = byte_q + 1'b1;
              tx_d   = 1'b0;
              shf_d  = pick_byte(hold_q, cksum_q, byte_q + 1'b1);
            end
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d  = shf_q[0];
              shf_d = {1'b0, shf_q[7:1]};
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shf_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      cmplt_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shf_q   <= shf_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      cmplt_q <= cmplt_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q  <= cmd;
      cksum_q <= calc_cksum(cmd);
    end
  end

  assign TX        = tx_q;
  assign cmd_rdy   = (state_q == IDLE);
  assign cmd_cmplt = cmplt_q;
  assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_comm_master_n.sv
// Bench for comm_master_n: four parameterisations checked cycle by cycle against
// a waveform model built from the command bytes and the 8N1 framing rules.
module tb_comm_master_n;

  logic         clk, rst;
  logic [3:0]   snd, tx_w, rdy_w, cmplt_w, drop_w;
  logic [15:0]  cmd_a, cmd_c;
  logic [23:0]  cmd_b;
  logic [127:0] cmd_d;
  int           compared, mismatched;
  logic         cap_tx[0:1023], cap_rdy[0:1023], cap_cmplt[0:1023], cap_drop[0:1023];
  logic [7:0]   exp_q[$];

  comm_master_n #(.NUM_BYTES(2), .BAUD_DIV(4), .CKSUM_EN(0)) u_a (
    .clk(clk), .rst(rst), .cmd(cmd_a), .snd_cmd(snd[0]), .TX(tx_w[0]),
    .cmd_rdy(rdy_w[0]), .cmd_cmplt(cmplt_w[0]), .cmd_drop(drop_w[0]));
  comm_master_n #(.NUM_BYTES(3), .BAUD_DIV(4), .CKSUM_EN(1)) u_b (
    .clk(clk), .rst(rst), .cmd(cmd_b), .snd_cmd(snd[1]), .TX(tx_w[1]),
    .cmd_rdy(rdy_w[1]), .cmd_cmplt(cmplt_w[1]), .cmd_drop(drop_w[1]));
  comm_master_n #(.NUM_BYTES(2), .BAUD_DIV(2), .CKSUM_EN(0)) u_c (
    .clk(clk), .rst(rst), .cmd(cmd_c), .snd_cmd(snd[2]), .TX(tx_w[2]),
    .cmd_rdy(rdy_w[2]), .cmd_cmplt(cmplt_w[2]), .cmd_drop(drop_w[2]));
  comm_master_n #(.NUM_BYTES(16), .BAUD_DIV(2), .CKSUM_EN(0)) u_d (
    .clk(clk), .rst(rst), .cmd(cmd_d), .snd_cmd(snd[3]), .TX(tx_w[3]),
    .cmd_rdy(rdy_w[3]), .cmd_cmplt(cmplt_w[3]), .cmd_drop(drop_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected byte sequence: payload MSB byte first, then 255 - (sum mod 256).
  function automatic void build_bytes(input logic [127:0] c, input int nb, input int ck);
    int sum;
    logic [7:0] b;
    exp_q.delete();
    sum = 0;
    for (int i = nb - 1; i >= 0; i--) begin
      b = c[8*i +: 8];
      exp_q.push_back(b);
      sum += int'(b);
    end
    if (ck != 0) exp_q.push_back(8'(255 - (sum % 256)));
  endfunction

  // Line level t cycles after the first start-bit cycle.
  function automatic logic model_bit(input int bd, input int t);
    int bl, bi, pos;
    logic [7:0] b;
    bl  = 10 * bd;
    bi  = t / bl;
    pos = (t % bl) / bd;
    if (bi >= exp_q.size()) return 1'b1;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = exp_q[bi];
    return b[pos-1];
  endfunction

  task automatic pulse_send(input int d);
    @(posedge clk); #1 snd[d] = 1'b1;
    @(posedge clk); #1 snd[d] = 1'b0;
  endtask

  // Records n cycles at the falling edge; snd is held high during cycles s_from..s_to.
  task automatic run(input int d, input int n, input int s_from, input int s_to);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      cap_tx[t]    = tx_w[d];
      cap_rdy[t]   = rdy_w[d];
      cap_cmplt[t] = cmplt_w[d];
      cap_drop[t]  = drop_w[d];
      snd[d]       = (t >= s_from && t <= s_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      compared++; if (tx_w[d] !== 1'b1) begin mismatched++; $display("FAIL reset_tx dut%0d got %b want 1", d, tx_w[d]); end
      compared++; if (rdy_w[d] !== 1'b1) begin mismatched++; $display("FAIL reset_rdy dut%0d got %b want 1", d, rdy_w[d]); end
      compared++; if (cmplt_w[d] !== 1'b0) begin mismatched++; $display("FAIL reset_cmplt dut%0d got %b want 0", d, cmplt_w[d]); end
      compared++; if (drop_w[d] !== 1'b0) begin mismatched++; $display("FAIL reset_drop dut%0d got %b want 0", d, drop_w[d]); end
    end
  endtask

  task automatic test_basic();
    int L;
    L = 80;
    cmd_a = 16'h12C3;
    build_bytes(128'(cmd_a), 2, 0);
    pulse_send(0);
    run(0, L + 10, 1, 0);
    for (int t = 0; t < L + 10; t++) begin
      compared++; if (cap_tx[t] !== model_bit(4, t)) begin mismatched++; $display("FAIL basic_tx cycle %0d got %b want %b", t, cap_tx[t], model_bit(4, t)); end
      compared++; if (cap_cmplt[t] !== (t >= L)) begin mismatched++; $display("FAIL basic_cmplt cycle %0d got %b want %b", t, cap_cmplt[t], (t >= L)); end
      compared++; if (cap_rdy[t] !== (t >= L)) begin mismatched++; $display("FAIL basic_rdy cycle %0d got %b want %b", t, cap_rdy[t], (t >= L)); end
      compared++; if (cap_drop[t] !== 1'b0) begin mismatched++; $display("FAIL basic_drop cycle %0d got %b want 0", t, cap_drop[t]); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_a = 16'hA55A;
    pulse_send(0);
    @(negedge clk);
    compared++; if (tx_w[0] !== 1'b0) begin mismatched++; $display("FAIL rstmid_start got %b want 0", tx_w[0]); end
    repeat (24) @(posedge clk);
    @(negedge clk);
    compared++; if (rdy_w[0] !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got %b want 0", rdy_w[0]); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run(0, 100, 1, 0);
    for (int t = 0; t < 100; t++) begin
      compared++; if (cap_tx[t] !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx cycle %0d got %b want 1", t, cap_tx[t]); end
      compared++; if (cap_rdy[t] !== 1'b1) begin mismatched++; $display("FAIL rstmid_rdy cycle %0d got %b want 1", t, cap_rdy[t]); end
      compared++; if (cap_cmplt[t] !== 1'b0) begin mismatched++; $display("FAIL rstmid_cmplt cycle %0d got %b want 0", t, cap_cmplt[t]); end
      compared++; if (cap_drop[t] !== 1'b0) begin mismatched++; $display("FAIL rstmid_drop cycle %0d got %b want 0", t, cap_drop[t]); end
    end
  endtask

  task automatic test_checksum();
    int L;
    L = 160;
    cmd_b = 24'h0102FF;
    build_bytes(128'(cmd_b), 3, 1);
    compared++; if (exp_q[3] !== 8'hFD) begin mismatched++; $display("FAIL cksum_model got %h want fd", exp_q[3]); end
    pulse_send(1);
    run(1, L + 10, 1, 0);
    for (int t = 0; t < L + 10; t++) begin
      compared++; if (cap_tx[t] !== model_bit(4, t)) begin mismatched++; $display("FAIL cksum_tx cycle %0d got %b want %b", t, cap_tx[t], model_bit(4, t)); end
      compared++; if (cap_cmplt[t] !== (t >= L)) begin mismatched++; $display("FAIL cksum_cmplt cycle %0d got %b want %b", t, cap_cmplt[t], (t >= L)); end
      compared++; if (cap_rdy[t] !== (t >= L)) begin mismatched++; $display("FAIL cksum_rdy cycle %0d got %b want %b", t, cap_rdy[t], (t >= L)); end
    end
  endtask

  task automatic test_latch_drop();
    int L;
    L = 80;
    cmd_a = 16'hBEEF;
    build_bytes(128'(cmd_a), 2, 0);
    pulse_send(0);
    cmd_a = 16'h0000;
    run(0, L + 10, 30, 30);
    for (int t = 0; t < L + 10; t++) begin
      compared++; if (cap_tx[t] !== model_bit(4, t)) begin mismatched++; $display("FAIL latch_tx cycle %0d got %b want %b", t, cap_tx[t], model_bit(4, t)); end
      compared++; if (cap_drop[t] !== (t == 31)) begin mismatched++; $display("FAIL latch_drop cycle %0d got %b want %b", t, cap_drop[t], (t == 31)); end
      compared++; if (cap_cmplt[t] !== (t >= L)) begin mismatched++; $display("FAIL latch_cmplt cycle %0d got %b want %b", t, cap_cmplt[t], (t >= L)); end
    end
  endtask

  task automatic test_back_to_back();
    int L, r;
    logic busy_prev;
    L = 40;
    cmd_c = 16'h0F0F;
    build_bytes(128'(cmd_c), 2, 0);
    @(posedge clk); #1 snd[2] = 1'b1;
    @(posedge clk); #1;
    run(2, 2 * (L + 1), 0, 2 * (L + 1) - 2);
    for (int t = 0; t < 2 * (L + 1); t++) begin
      r = t % (L + 1);
      busy_prev = (t >= 1) && (((t - 1) % (L + 1)) < L);
      compared++; if (cap_tx[t] !== ((r < L) ? model_bit(2, r) : 1'b1)) begin mismatched++; $display("FAIL b2b_tx cycle %0d got %b", t, cap_tx[t]); end
      compared++; if (cap_cmplt[t] !== (r == L)) begin mismatched++; $display("FAIL b2b_cmplt cycle %0d got %b want %b", t, cap_cmplt[t], (r == L)); end
      compared++; if (cap_rdy[t] !== (r == L)) begin mismatched++; $display("FAIL b2b_rdy cycle %0d got %b want %b", t, cap_rdy[t], (r == L)); end
      compared++; if (cap_drop[t] !== busy_prev) begin mismatched++; $display("FAIL b2b_drop cycle %0d got %b want %b", t, cap_drop[t], busy_prev); end
    end
  endtask

  task automatic test_width();
    int L;
    L = 320;
    cmd_d = 128'h000102030405060708090A0B0C0D0E0F;
    build_bytes(cmd_d, 16, 0);
    pulse_send(3);
    run(3, L + 8, 1, 0);
    for (int t = 0; t < L + 8; t++) begin
      compared++; if (cap_tx[t] !== model_bit(2, t)) begin mismatched++; $display("FAIL width_tx cycle %0d got %b want %b", t, cap_tx[t], model_bit(2, t)); end
      compared++; if (cap_cmplt[t] !== (t >= L)) begin mismatched++; $display("FAIL width_cmplt cycle %0d got %b want %b", t, cap_cmplt[t], (t >= L)); end
    end
  endtask

  task automatic test_random();
    int d, nb, ck, L, s;
    logic [127:0] c;
    for (int it = 0; it < 6; it++) begin
      d  = it % 2;
      nb = (d == 0) ? 2 : 3;
      ck = (d == 0) ? 0 : 1;
      L  = 40 * (nb + ck);
      if (d == 0) begin cmd_a = 16'($urandom); c = 128'(cmd_a); end
      else        begin cmd_b = 24'($urandom); c = 128'(cmd_b); end
      build_bytes(c, nb, ck);
      s = $urandom_range(0, L - 1);
      pulse_send(d);
      if (d == 0) cmd_a = ~cmd_a; else cmd_b = ~cmd_b;
      run(d, L + 6, s, s);
      for (int t = 0; t < L + 6; t++) begin
        compared++; if (cap_tx[t] !== model_bit(4, t)) begin mismatched++; $display("FAIL rand%0d_tx cycle %0d got %b want %b", it, t, cap_tx[t], model_bit(4, t)); end
        compared++; if (cap_cmplt[t] !== (t >= L)) begin mismatched++; $display("FAIL rand%0d_cmplt cycle %0d got %b want %b", it, t, cap_cmplt[t], (t >= L)); end
        compared++; if (cap_rdy[t] !== (t >= L)) begin mismatched++; $display("FAIL rand%0d_rdy cycle %0d got %b want %b", it, t, cap_rdy[t], (t >= L)); end
        compared++; if (cap_drop[t] !== (t == s + 1)) begin mismatched++; $display("FAIL rand%0d_drop cycle %0d got %b want %b", it, t, cap_drop[t], (t == s + 1)); end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    snd   = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_c = '0;
    cmd_d = '0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_checksum();
    test_latch_drop();
    test_back_to_back();
    test_width();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
